uart_tx_controller: RTL and testbench
=====================================

UART_TX_CONTROLLER -- requirements
Module: uart_tx_controller

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning TX FIFO depth in bytes; it must be a power of two and at least 2.
REQ-002 The block SHALL have parameter ADDR_RW, default 32'h10010000, meaning the UART data register address.
REQ-003 The block SHALL have parameter ADDR_STATUS, default 32'h10010005, meaning the UART status register address.
REQ-004 The block SHALL have parameter ADDR_CLKFREQ, default 32'h10010100, meaning the clock-frequency register address.
REQ-005 The block SHALL have parameter CLKFREQ_RESET, default 32'h0000ffc0, meaning the reset value of clk_frequency.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset (0 = in reset).
REQ-008 The block SHALL have port address, input, 32 bits: core data-bus address.
REQ-009 The block SHALL have port write_data, input, 32 bits: core store data.
REQ-010 The block SHALL have port write_enable, input, 1 bit: core store strobe, one transfer per high cycle.
REQ-011 The block SHALL have port read_data, output, 32 bits: combinational read data for a decoded address.
REQ-012 The block SHALL have port hit, output, 1 bit: address equals ADDR_RW, ADDR_STATUS or ADDR_CLKFREQ.
REQ-013 The block SHALL have port uart_data, output, 8 bits: byte presented to the transmitter.
REQ-014 The block SHALL have port uart_write_enable, output, 1 bit: one-cycle launch pulse to the transmitter.
REQ-015 The block SHALL have port uart_busy, input, 1 bit: transmitter busy.
REQ-016 The block SHALL have port uart_read_ready, input, 1 bit: receiver data-ready flag.
REQ-017 The block SHALL have port clk_frequency, output, 32 bits: registered clock-frequency configuration.

Function
REQ-018 A cycle with write_enable=1 and address=ADDR_RW SHALL push write_data[7:0] into the FIFO tail at that edge when the FIFO is not full.
REQ-019 The same write SHALL also load last_byte, which is read back at ADDR_RW as {24'b0,last_byte}; last_byte is loaded even when the FIFO is full.
REQ-020 A write to ADDR_RW while the FIFO is full and no pop occurs that cycle SHALL drop the byte and set the sticky overflow flag.
REQ-021 A write to ADDR_RW while full and a same-cycle pop SHALL be accepted, leaving count unchanged.
REQ-022 A simultaneous push and pop on a non-full FIFO SHALL leave count unchanged; the pointers wrap modulo DEPTH.
REQ-023 count SHALL be $clog2(DEPTH)+1 bits wide; full = (count==DEPTH); empty = (count==0).
REQ-024 The sequencer FSM SHALL have states IDLE, LAUNCH, WAIT_BUSY and WAIT_DONE.
REQ-025 From IDLE the FSM SHALL go to LAUNCH when !empty and !uart_busy; otherwise it stays in IDLE.
REQ-026 In LAUNCH, uart_write_enable SHALL be 1 and uart_data SHALL equal the FIFO head.
REQ-027 LAUNCH SHALL pop the FIFO at its exit edge and go to WAIT_BUSY unconditionally, clearing the 2-bit timeout counter.
REQ-028 In WAIT_BUSY the FSM SHALL go to WAIT_DONE when uart_busy=1; otherwise it increments the timeout counter and returns to IDLE after 4 cycles in WAIT_BUSY without seeing busy.
REQ-029 In WAIT_DONE the FSM SHALL go to IDLE when uart_busy=0.
REQ-030 Outside LAUNCH, uart_write_enable SHALL be 0 and uart_data SHALL still show the FIFO head (8'h00 when empty).
REQ-031 Latency: a write to an empty FIFO at edge N with the FSM in IDLE and uart_busy=0 SHALL assert uart_write_enable in the cycle after edge N+1 (launch pulse during cycle N+1..N+2).
REQ-032 Minimum spacing between launches SHALL be 4 cycles: LAUNCH, then at least 1 cycle in WAIT_BUSY, at least 1 in WAIT_DONE, and 1 in IDLE.
REQ-033 The status byte SHALL be {overflow, tx_active, full, 4'b0, uart_read_ready}, where tx_active = !empty | uart_busy | (state!=IDLE); ADDR_STATUS reads {24'b0,status}.
REQ-034 A write to ADDR_STATUS with write_data[7]=1 SHALL clear overflow; if an overflow-causing write occurs in the same cycle, set wins.
REQ-035 A write to ADDR_CLKFREQ SHALL load clk_frequency with write_data; ADDR_CLKFREQ reads clk_frequency.
REQ-036 For unmapped addresses, hit SHALL be 0 and read_data SHALL be 32'h0.
REQ-037 Writes to unmapped addresses SHALL have no effect.

Reset
REQ-038 While rst=0, asynchronously: FSM=IDLE, FIFO empty (pointers and count 0), overflow=0, last_byte=0, timeout counter=0, clk_frequency=CLKFREQ_RESET, uart_write_enable=0.
REQ-039 Reset mid-transmission SHALL abandon the FIFO contents, and no launch pulse is produced in the first cycle after release.

Verification
REQ-040 Reset, then a write of 8'h41 to ADDR_RW with uart_busy=0 -> exactly one uart_write_enable pulse with uart_data=8'h41, two cycles after the write; ADDR_RW then reads 32'h41.
REQ-041 9 back-to-back writes 8'h00..8'h08 with uart_busy held 1 -> first 8 are queued, the 9th sets overflow; status reads 32'hE0; status write 32'h80 -> status reads 32'h60.
REQ-042 Queue 3 bytes; a transmitter model asserts busy 1 cycle after each pulse for 10 cycles -> 3 pulses in FIFO order, each only after busy deasserts; tx_active falls after the 3rd completes.
REQ-043 Queue 1 byte with uart_busy tied 0 -> pulse, 4 cycles in WAIT_BUSY, then IDLE; no hang.
REQ-044 Write 32'h00989680 to ADDR_CLKFREQ -> clk_frequency=32'h00989680 next cycle; an unmapped read -> hit=0, read_data=0.
REQ-045 Assert rst=0 during WAIT_DONE with 4 bytes queued -> outputs reset immediately; after release, no pulse occurs and status reads {7'b0,uart_read_ready}.

Source files
------------

// File: rtl/uart_tx_controller.sv
// Memory-mapped UART transmit front end: byte FIFO, launch sequencer with busy
// handshake timeout, status/overflow register and clock-frequency register.
module uart_tx_controller #(
    parameter int unsigned DEPTH         = 8,
    parameter logic [31:0] ADDR_RW       = 32'h10010000,
    parameter logic [31:0] ADDR_STATUS   = 32'h10010005,
    parameter logic [31:0] ADDR_CLKFREQ  = 32'h10010100,
    parameter logic [31:0] CLKFREQ_RESET = 32'h0000ffc0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic        write_enable,
    output logic [31:0] read_data,
    output logic        hit,
    output logic [7:0]  uart_data,
    output logic        uart_write_enable,
    input  logic        uart_busy,
    input  logic        uart_read_ready,
    output logic [31:0] clk_frequency
);
    localparam int unsigned AW         = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t        state_q;
    logic          uart_we_q;
    logic [1:0]    timeout_q;
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    last_byte_q, last_byte_d;
    logic [31:0]   clk_freq_q, clk_freq_d;

    logic       sel_rw, sel_status, sel_clkfreq;
    logic       full, empty, push, pop, tx_active;
    logic [7:0] status;

    assign sel_rw      = (address == ADDR_RW);
    assign sel_status  = (address == ADDR_STATUS);
    assign sel_clkfreq = (address == ADDR_CLKFREQ);
    assign hit         = sel_rw | sel_status | sel_clkfreq;

    assign full  = (count_q == FULL_COUNT);
    assign empty = (count_q == '0);
    // The head leaves the FIFO on the edge that ends the launch pulse, so a
    // write landing on that same edge still fits even when the FIFO is full.
    assign pop   = (state_q == LAUNCH);
    assign push  = write_enable && sel_rw && (!full || pop);

    assign tx_active = !empty || uart_busy || (state_q != IDLE);
    assign status    = {overflow_q, tx_active, full, 4'b0000, uart_read_ready};

    assign uart_data         = empty ? 8'h00 : mem_q[rd_ptr_q];
    assign uart_write_enable = uart_we_q;
    assign clk_frequency     = clk_freq_q;

    always_comb begin
        read_data = 32'h0;
        if (sel_rw) begin
            read_data = {24'h0, last_byte_q};
        end else if (sel_status) begin
            read_data = {24'h0, status};
        end else if (sel_clkfreq) begin
            read_data = clk_freq_q;
        end
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = overflow_q;
        last_byte_d = last_byte_q;
        clk_freq_d  = clk_freq_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
        count_d = count_q + (AW + 1)'(push) - (AW + 1)'(pop);
        if (write_enable && sel_rw) last_byte_d = write_data[7:0];
        // Set is evaluated last so a dropped byte wins over a same-cycle clear.
        if (write_enable && sel_status && write_data[7]) overflow_d = 1'b0;
        if (write_enable && sel_rw && full && !pop) overflow_d = 1'b1;
        if (write_enable && sel_clkfreq) clk_freq_d = write_data;
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= write_data[7:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            last_byte_q <= 8'h00;
            clk_freq_q  <= CLKFREQ_RESET;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            last_byte_q <= last_byte_d;
            clk_freq_q  <= clk_freq_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            uart_we_q <= 1'b0;
            timeout_q <= 2'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!empty && !uart_busy) begin
                        state_q   <= LAUNCH;
                        uart_we_q <= 1'b1;
                    end
                end
                LAUNCH: begin
                    state_q   <= WAIT_BUSY;
                    uart_we_q <= 1'b0;
                    timeout_q <= 2'd0;
                end
                WAIT_BUSY: begin
                    // A transmitter that never raises busy must not stall the queue.
                    if (uart_busy) begin
                        state_q <= WAIT_DONE;
                    end else begin
                        timeout_q <= timeout_q + 2'd1;
                        if (timeout_q == 2'd3) state_q <= IDLE;
                    end
                end
                WAIT_DONE: begin
                    if (!uart_busy) state_q <= IDLE;
                end
                default: begin
                    state_q   <= IDLE;
                    uart_we_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_controller.sv
// Bench for uart_tx_controller: directed scenarios followed by random bus
// traffic, checked against a queue-based model of the FIFO and registers.
module tb_uart_tx_controller;
  localparam int DEPTH = 8;
  localparam logic [31:0] A_RW = 32'h10010000;
  localparam logic [31:0] A_ST = 32'h10010005;
  localparam logic [31:0] A_CF = 32'h10010100;
  localparam logic [31:0] A_UN = 32'h10010004;
  localparam logic [31:0] CF_RESET = 32'h0000ffc0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [31:0] address = 32'h0;
  logic [31:0] write_data = 32'h0;
  logic write_enable = 1'b0;
  logic uart_busy = 1'b0;
  logic uart_read_ready = 1'b0;
  logic [31:0] read_data;
  logic hit;
  logic [7:0] uart_data;
  logic uart_write_enable;
  logic [31:0] clk_frequency;

  always #5 clk = ~clk;

  uart_tx_controller #(.DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .address(address),
    .write_data(write_data),
    .write_enable(write_enable),
    .read_data(read_data),
    .hit(hit),
    .uart_data(uart_data),
    .uart_write_enable(uart_write_enable),
    .uart_busy(uart_busy),
    .uart_read_ready(uart_read_ready),
    .clk_frequency(clk_frequency)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: FIFO contents as a queue plus register shadows.
  logic [7:0] exp_q[$];
  logic m_ovf = 1'b0;
  logic [7:0] m_last = 8'h00;
  logic [31:0] m_clk = CF_RESET;

  // Transmitter model and launch bookkeeping.
  int pulse_count = 0;
  int gap = 100;
  int busy_left = 0;
  int tx_k = 3;
  int stall = 0;
  int max_stall = 0;
  bit tx_drop = 1'b0;
  bit tx_force = 1'b0;
  logic busy_step = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ovf = 1'b0;
    m_last = 8'h00;
    m_clk = CF_RESET;
  endtask

  // One clock: drive inputs just after a falling edge, advance the model for
  // the coming rising edge, then check outputs at the next falling edge.
  task automatic step(input logic we_i, input logic [31:0] a, input logic [31:0] d);
    logic pop;
    logic was_full;
    logic ovf_set;
    logic [7:0] hd;
    logic [31:0] exp_rd;
    logic [31:0] mask;
    write_enable = we_i;
    address = a;
    write_data = d;
    if (tx_force) uart_busy = 1'b1;
    else if (busy_left > 0) begin
      uart_busy = 1'b1;
      busy_left--;
    end else uart_busy = 1'b0;
    busy_step = uart_busy;
    if (!rst) model_reset();
    else begin
      pop = uart_write_enable;
      was_full = (exp_q.size() == DEPTH);
      ovf_set = 1'b0;
      if (pop && exp_q.size() > 0) void'(exp_q.pop_front());
      if (we_i && a == A_RW) begin
        m_last = d[7:0];
        if (!was_full || pop) exp_q.push_back(d[7:0]);
        else ovf_set = 1'b1;
      end
      if (we_i && a == A_ST && d[7]) m_ovf = 1'b0;
      if (ovf_set) m_ovf = 1'b1;
      if (we_i && a == A_CF) m_clk = d;
    end
    @(posedge clk);
    @(negedge clk);
    hd = (exp_q.size() != 0) ? exp_q[0] : 8'h00;
    check("uart_data", {24'h0, uart_data}, {24'h0, hd});
    check("clk_frequency", clk_frequency, m_clk);
    if (uart_write_enable) begin
      pulse_count++;
      check("launch_rule", {29'h0, busy_step, exp_q.size() == 0, gap < 3}, 32'h0);
      gap = 0;
      stall = 0;
      if (!tx_drop) busy_left = tx_k;
    end else begin
      gap++;
      if (exp_q.size() != 0 && !tx_force && rst) stall++;
      else stall = 0;
      if (stall > max_stall) max_stall = stall;
    end
    mask = 32'hffffffff;
    case (address)
      A_RW: exp_rd = {24'h0, m_last};
      A_ST: begin
        exp_rd = {24'h0, m_ovf, 1'b1, exp_q.size() == DEPTH, 4'b0000, uart_read_ready};
        if (exp_q.size() == 0 && !uart_busy) mask[6] = 1'b0;
      end
      A_CF: exp_rd = m_clk;
      default: exp_rd = 32'h0;
    endcase
    check("read_data", read_data & mask, exp_rd & mask);
    check("hit", {31'h0, hit}, {31'h0, (address == A_RW || address == A_ST || address == A_CF)});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, A_ST, 32'h0);
  endtask

  initial begin
    int p0;
    bit found;
    int r;

    // Reset and reset-state values.
    idle(2);
    rst = 1'b1;
    step(1'b0, A_RW, 32'h0);
    check("rst_we", {31'h0, uart_write_enable}, 32'h0);
    check("rst_rw", read_data, 32'h0);
    check("rst_clkfreq", clk_frequency, CF_RESET);
    step(1'b0, A_ST, 32'h0);
    check("rst_status", read_data, 32'h0);

    // Single byte: pulse two edges after the write, exactly once.
    tx_k = 3;
    p0 = pulse_count;
    step(1'b1, A_RW, 32'h00000041);
    check("t1_no_early", {31'h0, uart_write_enable}, 32'h0);
    step(1'b0, A_RW, 32'h0);
    check("t1_pulse", {31'h0, uart_write_enable}, 32'h1);
    check("t1_data", {24'h0, uart_data}, 32'h41);
    step(1'b0, A_RW, 32'h0);
    check("t1_pulse_end", {31'h0, uart_write_enable}, 32'h0);
    check("t1_readback", read_data, 32'h41);
    idle(15);
    check("t1_pulses", pulse_count - p0, 32'd1);

    // Nine writes with busy held: eight queue, the ninth overflows.
    tx_force = 1'b1;
    for (int i = 0; i < 9; i++) step(1'b1, A_RW, i);
    step(1'b0, A_ST, 32'h0);
    check("t2_status_ovf", read_data, 32'hE0);
    step(1'b1, A_ST, 32'h80);
    check("t2_status_clr", read_data, 32'h60);
    // Release busy and write into the full FIFO on the pop edge.
    tx_force = 1'b0;
    p0 = pulse_count;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b0, A_ST, 32'h0);
      if (uart_write_enable) found = 1'b1;
    end
    check("t2_launch_seen", {31'h0, found}, 32'h1);
    step(1'b1, A_RW, 32'h00000099);
    step(1'b0, A_ST, 32'h0);
    check("t2_full_pop_accept", read_data, 32'h60);
    idle(100);
    check("t2_drained", exp_q.size(), 32'd0);
    check("t2_pulses", pulse_count - p0, 32'd9);

    // Three bytes with a slow transmitter; tx_active falls after the last.
    tx_k = 10;
    p0 = pulse_count;
    step(1'b1, A_RW, 32'hA1);
    step(1'b1, A_RW, 32'hB2);
    step(1'b1, A_RW, 32'hC3);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step(1'b0, A_ST, 32'h0);
      if (!read_data[6]) found = 1'b1;
    end
    check("t3_tx_active_fall", {31'h0, found}, 32'h1);
    check("t3_pulses", pulse_count - p0, 32'd3);

    // Busy never rises: four cycles of waiting, then back to idle.
    tx_drop = 1'b1;
    step(1'b1, A_RW, 32'h5A);
    step(1'b0, A_ST, 32'h0);
    check("t4_pulse", {31'h0, uart_write_enable}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, A_ST, 32'h0);
      check("t4_wait_busy", read_data, 32'h40);
    end
    step(1'b0, A_ST, 32'h0);
    check("t4_idle", read_data, 32'h00);
    step(1'b1, A_RW, 32'h11);
    step(1'b1, A_RW, 32'h22);
    idle(20);
    check("t4_drained", exp_q.size(), 32'd0);
    tx_drop = 1'b0;

    // Clock-frequency register and unmapped accesses.
    step(1'b1, A_CF, 32'h00989680);
    check("t5_clkfreq", clk_frequency, 32'h00989680);
    step(1'b0, A_UN, 32'h0);
    check("t5_unmapped_hit", {31'h0, hit}, 32'h0);
    check("t5_unmapped_rd", read_data, 32'h0);
    step(1'b1, A_UN, 32'hffffffff);
    step(1'b1, 32'h10010001, 32'hffffffff);
    step(1'b0, A_RW, 32'h0);
    check("t5_unmapped_wr_rw", read_data, 32'h22);
    step(1'b0, A_CF, 32'h0);
    check("t5_unmapped_wr_cf", read_data, 32'h00989680);

    // Reset while waiting for the transmitter with four bytes still queued.
    tx_k = 60;
    for (int i = 0; i < 5; i++) step(1'b1, A_RW, 32'h60 + i);
    idle(2);
    check("t6_queued", exp_q.size(), 32'd4);
    address = A_ST;
    write_enable = 1'b0;
    uart_busy = 1'b0;
    busy_left = 0;
    uart_read_ready = 1'b1;
    rst = 1'b0;
    #1;
    model_reset();
    check("t6_async_we", {31'h0, uart_write_enable}, 32'h0);
    check("t6_async_data", {24'h0, uart_data}, 32'h0);
    check("t6_async_clkfreq", clk_frequency, CF_RESET);
    check("t6_async_status", read_data, 32'h01);
    idle(2);
    rst = 1'b1;
    p0 = pulse_count;
    idle(10);
    check("t6_no_pulse", pulse_count - p0, 32'd0);
    check("t6_status", read_data, 32'h01);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      tx_k = $urandom_range(1, 6);
      tx_drop = ($urandom_range(0, 4) == 0);
      uart_read_ready = $urandom_range(0, 1);
      r = $urandom_range(0, 99);
      if (r < 40) step(1'b1, A_RW, $urandom);
      else if (r < 48) step(1'b1, A_ST, $urandom);
      else if (r < 52) step(1'b1, A_CF, $urandom);
      else if (r < 56) step(1'b1, A_UN, $urandom);
      else begin
        case ($urandom_range(0, 3))
          0: step(1'b0, A_RW, 32'h0);
          1: step(1'b0, A_ST, 32'h0);
          2: step(1'b0, A_CF, 32'h0);
          default: step(1'b0, A_UN, 32'h0);
        endcase
      end
    end
    tx_drop = 1'b0;
    tx_k = 2;
    idle(120);
    check("rand_drained", exp_q.size(), 32'd0);
    check("no_stall", {31'h0, max_stall > 30}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
